lock_controller: RTL and testbench
==================================

Name: lock_controller

Overview:
- Consumes the 4-digit BCD entry produced by the keypad password-entry stage: a 16-bit code, digit 1 in [15:12], plus a one-cycle valid strobe.
- Compares the entry against a stored password and drives unlock and alarm.
- Enforces a retry limit with a timed lockout and a timed auto-relock.
- Supports changing the password while unlocked, using new-then-confirm entry.

Parameters:
- DEFAULT_PASS, 16'h1234, password loaded on reset
- MAX_TRIES, 3, consecutive wrong entries that trigger lockout (range 1..7)
- UNLOCK_CYCLES, 32'd500000000, cycles the lock stays open before auto-relock (range 1 to 2^32-1)
- LOCKOUT_CYCLES, 32'd1000000000, cycles the lockout lasts; input is ignored during it (range 1 to 2^32-1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- code  input  16  4-digit BCD entry, digit 1 in [15:12]
- code_valid  input  1  one-cycle strobe; code is stable while high
- set_req  input  1  level; request a password change, honoured only when UNLOCKED
- lock_cmd  input  1  level; immediate relock, honoured only in UNLOCKED/SET_NEW/CONFIRM_NEW
- unlocked  output  1  high in UNLOCKED, SET_NEW, CONFIRM_NEW
- alarm  output  1  high in LOCKOUT
- fail_cnt  output  3  consecutive wrong entries
- busy_set  output  1  high in SET_NEW, CONFIRM_NEW
- pass_changed  output  1  one-cycle pulse when a new password is committed

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it wins over every other input.
- Reset values:
  - state = LOCKED
  - password register = DEFAULT_PASS
  - fail_cnt = 0, timer = 0
  - unlocked = 0, alarm = 0, busy_set = 0, pass_changed = 0
- Register timing: all outputs are registered. A response appears in the cycle after the posedge that samples code_valid (1-cycle latency).
- LOCKED:
  - code_valid with code == password: go to UNLOCKED, fail_cnt = 0, timer = 0.
  - code_valid with a mismatch, fail_cnt+1 < MAX_TRIES: increment fail_cnt, stay LOCKED.
  - code_valid with a mismatch, fail_cnt+1 == MAX_TRIES: go to LOCKOUT, fail_cnt = MAX_TRIES, timer = 0.
- LOCKOUT:
  - code_valid, set_req and lock_cmd are ignored.
  - timer counts up. When timer == LOCKOUT_CYCLES-1: go to LOCKED, fail_cnt = 0, alarm drops.
- UNLOCKED, priority order:
  - lock_cmd: go to LOCKED.
  - else set_req: go to SET_NEW, timer = 0.
  - else timer == UNLOCK_CYCLES-1: go to LOCKED (auto-relock).
  - code_valid here is ignored and does not reset the timer.
- SET_NEW:
  - lock_cmd: go to LOCKED, password unchanged.
  - code_valid: capture code into a pending register, go to CONFIRM_NEW.
  - The UNLOCK_CYCLES timer keeps running. Expiry goes to LOCKED and discards the pending value.
- CONFIRM_NEW:
  - code_valid with code == pending: write the password register, pulse pass_changed, go to UNLOCKED, timer = 0.
  - code_valid with a mismatch: go to UNLOCKED, password unchanged, no pass_changed.
  - lock_cmd and timer expiry behave as in SET_NEW.
- Non-BCD nibbles (A–F) are compared bitwise like any other value; there is no special handling.
- fail_cnt saturates at MAX_TRIES and never wraps.
- Timer: 32-bit, cleared on every state change.
- Simultaneous code_valid and lock_cmd in SET_NEW or CONFIRM_NEW: lock_cmd wins and nothing is committed.
- Reset in any state, including mid-lockout or mid-change: password returns to DEFAULT_PASS.

Decomposition:
- Shared package lock_pkg holds:
  - state enum encoding: LOCKED=0, UNLOCKED=1, SET_NEW=2, CONFIRM_NEW=3, LOCKOUT=4
  - the 16-bit code width constant
- One sub-module, lock_timer: loadable up-counter with a terminal-count flag, instantiated once and shared by unlock and lockout.

Test Plan (MAX_TRIES=3, UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50 for sim):
- Reset, then code=16'h1234 with code_valid -> unlocked=1 next cycle, fail_cnt=0. With no input, unlocked=0 exactly 20 cycles later.
- Three strobes with code=16'h1111 -> fail_cnt 1, 2, then alarm=1. A strobe of 16'h1234 during lockout -> no unlock. alarm=0 and fail_cnt=0 after 50 cycles.
- Two wrong entries then 16'h1234 -> unlocked=1, fail_cnt=0. A further wrong entry after relock -> fail_cnt=1, not lockout.
- Unlock, set_req, code=16'h9876, then code=16'h9876 -> pass_changed pulses once. Relock via lock_cmd. 16'h1234 then fails (fail_cnt=1) and 16'h9876 unlocks.
- Unlock, set_req, 16'h5555 then 16'h5556 -> unlocked stays 1, no pass_changed, password still 16'h1234.
- In CONFIRM_NEW, lock_cmd and a matching code_valid in the same cycle -> LOCKED, password unchanged. Then rst mid-lockout -> all outputs at reset values.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types for the lock controller: state encoding and code width.
// Pure declarations; no timing or flow control of its own.
package lock_pkg;

    localparam int CODE_W = 16;

    typedef enum logic [2:0] {
        LOCKED      = 3'd0,
        UNLOCKED    = 3'd1,
        SET_NEW     = 3'd2,
        CONFIRM_NEW = 3'd3,
        LOCKOUT     = 3'd4
    } state_e;

    function automatic logic is_open(input state_e s);
        return (s == UNLOCKED) || (s == SET_NEW) || (s == CONFIRM_NEW);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Clearable up-counter with a terminal-count flag against a runtime limit.
// Flag is combinational from the count register; no backpressure.
module lock_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/lock_controller.sv
// Password lock with retry lockout, auto-relock and confirm-before-commit password change.
// All outputs registered: response one cycle after the sampling edge; inputs are never stalled.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_PASS   = 16'h1234,
    parameter int                MAX_TRIES      = 3,
    parameter logic [31:0]       UNLOCK_CYCLES  = 32'd500000000,
    parameter logic [31:0]       LOCKOUT_CYCLES = 32'd1000000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              set_req,
    input  logic              lock_cmd,
    output logic              unlocked,
    output logic              alarm,
    output logic [2:0]        fail_cnt,
    output logic              busy_set,
    output logic              pass_changed
);

    localparam logic [3:0] MAX4 = 4'(MAX_TRIES);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] pass_q, pass_d;
    logic [CODE_W-1:0] pend_q, pend_d;
    logic [2:0]        fail_q, fail_d;
    logic              pc_d, pc_q;
    logic              unlocked_q, alarm_q, busy_q;
    logic [3:0]        fail_inc;
    logic [31:0]       term;
    logic              tmr_clr, tmr_tc;

    assign fail_inc = {1'b0, fail_q} + 4'd1;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        pend_d  = pend_q;
        fail_d  = fail_q;
        pc_d    = 1'b0;
        term    = UNLOCK_CYCLES - 32'd1;
        case (state_q)
            LOCKED: begin
                if (code_valid) begin
                    if (code == pass_q) begin
                        state_d = UNLOCKED;
                        fail_d  = 3'd0;
                    end else if (fail_inc >= MAX4) begin
                        state_d = LOCKOUT;
                        fail_d  = MAX4[2:0];
                    end else begin
                        fail_d  = fail_inc[2:0];
                    end
                end
            end
            LOCKOUT: begin
                term = LOCKOUT_CYCLES - 32'd1;
                if (tmr_tc) begin
                    state_d = LOCKED;
                    fail_d  = 3'd0;
                end
            end
            UNLOCKED: begin
                if (lock_cmd)     state_d = LOCKED;
                else if (set_req) state_d = SET_NEW;
                else if (tmr_tc)  state_d = LOCKED;
            end
            SET_NEW: begin
                if (lock_cmd) begin
                    state_d = LOCKED;
                end else if (code_valid) begin
                    pend_d  = code;
                    state_d = CONFIRM_NEW;
                end else if (tmr_tc) begin
                    state_d = LOCKED;
                end
            end
            CONFIRM_NEW: begin
                // A mismatched confirm abandons the change but keeps the lock open.
                if (lock_cmd) begin
                    state_d = LOCKED;
                end else if (code_valid) begin
                    state_d = UNLOCKED;
                    if (code == pend_q) begin
                        pass_d = code;
                        pc_d   = 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // Timer restarts on every state change and idles at zero while locked.
    assign tmr_clr = (state_d != state_q) || (state_q == LOCKED);

    lock_timer #(.W(32)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr),
        .term_i (term),
        .tc_o   (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCKED;
            pass_q     <= DEFAULT_PASS;
            pend_q     <= '0;
            fail_q     <= 3'd0;
            pc_q       <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            pend_q     <= pend_d;
            fail_q     <= fail_d;
            pc_q       <= pc_d;
            unlocked_q <= is_open(state_d);
            alarm_q    <= (state_d == LOCKOUT);
            busy_q     <= (state_d == SET_NEW) || (state_d == CONFIRM_NEW);
        end
    end

    assign unlocked     = unlocked_q;
    assign alarm        = alarm_q;
    assign fail_cnt     = fail_q;
    assign busy_set     = busy_q;
    assign pass_changed = pc_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a countdown-based reference model checked every cycle.
module tb_lock_controller;

    localparam int U  = 20;
    localparam int L  = 50;
    localparam int MT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] code = 16'h0;
    logic        code_valid = 1'b0;
    logic        set_req = 1'b0;
    logic        lock_cmd = 1'b0;
    logic        unlocked, alarm, busy_set, pass_changed;
    logic [2:0]  fail_cnt;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    lock_controller #(
        .DEFAULT_PASS   (16'h1234),
        .MAX_TRIES      (MT),
        .UNLOCK_CYCLES  (32'(U)),
        .LOCKOUT_CYCLES (32'(L))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .code         (code),
        .code_valid   (code_valid),
        .set_req      (set_req),
        .lock_cmd     (lock_cmd),
        .unlocked     (unlocked),
        .alarm        (alarm),
        .fail_cnt     (fail_cnt),
        .busy_set     (busy_set),
        .pass_changed (pass_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 closed, 1 open, 2 entering new, 3 confirming, 4 lockout.
    // rem counts the clock edges left before the timed mode expires.
    int          m_mode = 0;
    int          m_rem = 0;
    int          m_fails = 0;
    logic [15:0] m_pass = 16'h1234;
    logic [15:0] m_pend = 16'h0;
    bit          m_pc = 0;

    task automatic tick_open();
        m_rem--;
        if (m_rem == 0) m_mode = 0;
    endtask

    always @(posedge clk) begin
        m_pc = 0;
        if (rst) begin
            m_mode = 0; m_rem = 0; m_fails = 0; m_pass = 16'h1234;
        end else begin
            case (m_mode)
                0: if (code_valid) begin
                    if (code == m_pass) begin
                        m_mode = 1; m_fails = 0; m_rem = U;
                    end else if (m_fails + 1 >= MT) begin
                        m_mode = 4; m_fails = MT; m_rem = L;
                    end else begin
                        m_fails++;
                    end
                end
                4: begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 0; m_fails = 0; end
                end
                1: if (lock_cmd) m_mode = 0;
                   else if (set_req) begin m_mode = 2; m_rem = U; end
                   else tick_open();
                2: if (lock_cmd) m_mode = 0;
                   else if (code_valid) begin m_pend = code; m_mode = 3; m_rem = U; end
                   else tick_open();
                3: if (lock_cmd) m_mode = 0;
                   else if (code_valid) begin
                       if (code == m_pend) begin m_pass = code; m_pc = 1; end
                       m_mode = 1; m_rem = U;
                   end else tick_open();
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_unlocked", unlocked, (m_mode >= 1 && m_mode <= 3) ? 1 : 0);
            chk("model_alarm", alarm, (m_mode == 4) ? 1 : 0);
            chk("model_busy_set", busy_set, (m_mode == 2 || m_mode == 3) ? 1 : 0);
            chk("model_fail_cnt", fail_cnt, m_fails);
            chk("model_pass_changed", pass_changed, m_pc);
        end
    end

    task automatic strobe(input logic [15:0] c);
        @(negedge clk);
        code = c; code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic pulse_set();
        @(negedge clk); set_req = 1'b1;
        @(negedge clk); set_req = 1'b0;
    endtask

    task automatic pulse_lock();
        @(negedge clk); lock_cmd = 1'b1;
        @(negedge clk); lock_cmd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_alarm"}, alarm, 0);
        chk({tag, "_fail"}, fail_cnt, 0);
        chk({tag, "_busy"}, busy_set, 0);
        chk({tag, "_pc"}, pass_changed, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        started = 1;
        chk_all_reset("reset");

        // Unlock and auto-relock after exactly U cycles
        strobe(16'h1234);
        chk("unlock_open", unlocked, 1);
        chk("unlock_fail0", fail_cnt, 0);
        idle(U - 1);
        chk("relock_not_yet", unlocked, 1);
        idle(1);
        chk("relock_done", unlocked, 0);

        // Three wrong entries -> lockout; correct code ignored during it
        strobe(16'h1111); chk("wrong1", fail_cnt, 1);
        strobe(16'h1111); chk("wrong2", fail_cnt, 2);
        strobe(16'h1111); chk("lockout_alarm", alarm, 1); chk("lockout_fail", fail_cnt, 3);
        strobe(16'h1234); chk("lockout_ignore", unlocked, 0);
        idle(L - 3);
        chk("lockout_not_yet", alarm, 1);
        idle(1);
        chk("lockout_end_alarm", alarm, 0);
        chk("lockout_end_fail", fail_cnt, 0);

        // Two wrong then right clears the count; one wrong after relock is not lockout
        strobe(16'h1111); strobe(16'h2222);
        chk("two_wrong", fail_cnt, 2);
        strobe(16'h1234);
        chk("late_unlock", unlocked, 1); chk("late_fail0", fail_cnt, 0);
        pulse_lock();
        chk("lock_cmd", unlocked, 0);
        strobe(16'h1111);
        chk("after_relock_fail", fail_cnt, 1); chk("after_relock_alarm", alarm, 0);

        // Successful password change
        strobe(16'h1234);
        pulse_set();
        chk("set_busy", busy_set, 1);
        strobe(16'h9876);
        chk("set_new_busy", busy_set, 1); chk("set_new_nopc", pass_changed, 0);
        strobe(16'h9876);
        chk("commit_pc", pass_changed, 1); chk("commit_busy", busy_set, 0); chk("commit_open", unlocked, 1);
        chk("model_pass", m_pass, 16'h9876);
        idle(1);
        chk("commit_pc_once", pass_changed, 0);
        pulse_lock();
        strobe(16'h1234);
        chk("old_pass_fails", fail_cnt, 1); chk("old_pass_closed", unlocked, 0);
        strobe(16'h9876);
        chk("new_pass_opens", unlocked, 1);

        // Reset restores the default password
        do_reset();
        chk_all_reset("reset2");

        // Mismatched confirmation keeps the old password
        strobe(16'h1234);
        pulse_set();
        strobe(16'h5555);
        strobe(16'h5556);
        chk("mismatch_open", unlocked, 1); chk("mismatch_busy", busy_set, 0); chk("mismatch_pc", pass_changed, 0);
        pulse_lock();
        strobe(16'h1234);
        chk("mismatch_pass_kept", unlocked, 1);

        // lock_cmd beats a matching confirm in the same cycle
        pulse_set();
        strobe(16'h4321);
        @(negedge clk);
        code = 16'h4321; code_valid = 1'b1; lock_cmd = 1'b1;
        @(negedge clk);
        code_valid = 1'b0; lock_cmd = 1'b0;
        chk("lock_wins_closed", unlocked, 0); chk("lock_wins_pc", pass_changed, 0);
        strobe(16'h4321);
        chk("lock_wins_new_rejected", fail_cnt, 1);
        strobe(16'h1234);
        chk("lock_wins_old_kept", unlocked, 1);
        pulse_lock();

        // Reset in the middle of a lockout
        strobe(16'hAAAA); strobe(16'hBBBB); strobe(16'hCCCC);
        chk("lockout2_alarm", alarm, 1);
        idle(5);
        do_reset();
        chk_all_reset("reset_mid_lockout");
        strobe(16'h1234);
        chk("post_reset_unlock", unlocked, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
